// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment patterns and display geometry for the seven-segment scanner
package seg7_pkg;
  localparam int SEG_W = 7;
  localparam int NDIG  = 4;
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
endpackage

// File: rtl/bcd7seg.sv
// bcd7seg: active-low {g,f,e,d,c,b,a} decode of one BCD digit, non-decimal codes shown as a dash
module bcd7seg
  import seg7_pkg::*;
(
  input  logic [3:0]       bcd,
  output logic [SEG_W-1:0] seg
);
  // pure lookup; codes 10..15 fall through to the dash pattern
  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed four-digit seven-segment driver with frame snapshot and leading-zero blanking
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [4*NDIG-1:0]   digits,
  input  logic [NDIG-1:0]     dp_in,
  input  logic                blank_lz,
  output logic [NDIG-1:0]     an,
  output logic [SEG_W-1:0]    seg,
  output logic                dp
);
  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  logic [PW-1:0]      presc_q, presc_d;
  logic [1:0]         idx_q, idx_d;
  logic [4*NDIG-1:0]  snap_dig_q, snap_dig_d;
  logic [NDIG-1:0]    snap_dp_q, snap_dp_d;
  logic [NDIG-1:0]    an_q, an_d;
  logic [SEG_W-1:0]   seg_q, seg_d;
  logic               dp_q, dp_d;
  logic               tick;
  logic [3:0]         cur_dig;
  logic [SEG_W-1:0]   dec_seg;
  logic [NDIG-1:0]    blank;
  logic [NDIG-1:1]    zero;
  // slot timing: prescaler wraps into a tick, ticks step the digit index, and the snapshot is only refreshed at the frame boundary
  always_comb begin
    tick       = presc_q == PW'(SCAN_DIV - 1);
    presc_d    = tick ? '0 : presc_q + 1'b1;
    idx_d      = tick ? idx_q + 2'd1 : idx_q;
    snap_dig_d = (tick && idx_q == 2'd3) ? digits : snap_dig_q;
    snap_dp_d  = (tick && idx_q == 2'd3) ? dp_in : snap_dp_q;
  end
  // per-slot output: a digit is blanked only when it and every digit above it are zero
  always_comb begin
    cur_dig = snap_dig_q[{idx_q, 2'b00} +: 4];
    zero    = {snap_dig_q[15:12] == 4'd0, snap_dig_q[11:8] == 4'd0, snap_dig_q[7:4] == 4'd0};
    blank   = blank_lz ? {zero[3], &zero[3:2], &zero[3:1], 1'b0} : '0;
    an_d    = en ? ~(4'b0001 << idx_q) : 4'b1111;
    seg_d   = blank[idx_q] ? SEG_BLANK : dec_seg;
    dp_d    = blank[idx_q] | ~snap_dp_q[idx_q];
  end
  bcd7seg u_dec (
    .bcd(cur_dig),
    .seg(dec_seg)
  );
  // state and registered display outputs; reset leaves the display dark and the snapshot cleared
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q    <= '0;
      idx_q      <= '0;
      snap_dig_q <= '0;
      snap_dp_q  <= '0;
      an_q       <= '1;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b1;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      snap_dig_q <= snap_dig_d;
      snap_dp_q  <= snap_dp_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end
  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed scenario checks of the seven-segment scanner with SCAN_DIV=4
module tb_seg7_scan;
  logic        clk = 1'b0;
  logic        rst, en, blank_lz, dp;
  logic [15:0] digits;
  logic [3:0]  dp_in, an;
  logic [6:0]  seg;
  int errors = 0;
  int checks = 0;
  int k = 0;
  localparam logic [3:0] AN_EXP [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  always #5 clk = ~clk;
  seg7_scan #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .en(en), .digits(digits), .dp_in(dp_in),
    .blank_lz(blank_lz), .an(an), .seg(seg), .dp(dp)
  );
  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask
  task automatic to_frame_start();
    while (k % 16 != 0) step();
  endtask
  task automatic test_reset();
    en = 1'b1; blank_lz = 1'b0; digits = 16'h1234; dp_in = 4'b0000; rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: an=%b seg=%b dp=%b, required an=1111 seg=1111111 dp=1", i, an, seg, dp);
      end
    end
    rst = 1'b0; k = 0;
    step();
    checks++;
    if (an !== 4'b1110 || seg !== 7'b1000000 || dp !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: an=%b seg=%b dp=%b, required an=1110 seg=1000000 dp=1", an, seg, dp);
    end
  endtask
  task automatic test_scan();
    logic [6:0] es [4];
    es = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    for (int i = 0; i < 15; i++) begin
      step();
      checks++;
      if (seg !== 7'b1000000) begin
        errors++;
        $display("FAIL first_frame_zero pos %0d: seg=%b, required 1000000", i + 1, seg);
      end
    end
    for (int j = 0; j < 16; j++) begin
      step();
      checks++;
      if (an !== AN_EXP[j/4] || seg !== es[j/4] || dp !== 1'b1) begin
        errors++;
        $display("FAIL scan pos %0d: an=%b seg=%b dp=%b, required an=%b seg=%b dp=1", j, an, seg, dp, AN_EXP[j/4], es[j/4]);
      end
    end
  endtask
  task automatic test_leading_zero();
    logic [6:0] es [4];
    es = '{7'b1000000, 7'b0010010, 7'b1111111, 7'b1111111};
    digits = 16'h0050; blank_lz = 1'b1;
    step();
    to_frame_start();
    for (int j = 0; j < 16; j++) begin
      step();
      checks++;
      if (an !== AN_EXP[j/4] || seg !== es[j/4] || dp !== 1'b1) begin
        errors++;
        $display("FAIL leading_zero pos %0d: an=%b seg=%b dp=%b, required an=%b seg=%b dp=1", j, an, seg, dp, AN_EXP[j/4], es[j/4]);
      end
    end
  endtask
  task automatic test_dash_dp();
    logic [6:0] es [4];
    logic       ed;
    es = '{7'b0111111, 7'b0111111, 7'b1000000, 7'b1000000};
    digits = 16'h00AF; dp_in = 4'b0010; blank_lz = 1'b0;
    step();
    to_frame_start();
    for (int j = 0; j < 16; j++) begin
      step();
      ed = (j / 4 == 1) ? 1'b0 : 1'b1;
      checks++;
      if (an !== AN_EXP[j/4] || seg !== es[j/4] || dp !== ed) begin
        errors++;
        $display("FAIL dash_dp pos %0d: an=%b seg=%b dp=%b, required an=%b seg=%b dp=%b", j, an, seg, dp, AN_EXP[j/4], es[j/4], ed);
      end
    end
  endtask
  task automatic test_tearing();
    logic [6:0] eo [4];
    logic [6:0] en_s [4];
    eo   = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    en_s = '{7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010};
    digits = 16'h1234; dp_in = 4'b0000; blank_lz = 1'b0;
    step();
    to_frame_start();
    for (int j = 0; j < 16; j++) begin
      step();
      checks++;
      if (seg !== eo[j/4]) begin
        errors++;
        $display("FAIL tearing_old pos %0d: seg=%b, required %b", j, seg, eo[j/4]);
      end
      if (j == 4) digits = 16'h5678;
    end
    for (int j = 0; j < 16; j++) begin
      step();
      checks++;
      if (an !== AN_EXP[j/4] || seg !== en_s[j/4]) begin
        errors++;
        $display("FAIL tearing_new pos %0d: an=%b seg=%b, required an=%b seg=%b", j, an, seg, AN_EXP[j/4], en_s[j/4]);
      end
    end
  endtask
  task automatic test_enable();
    logic [3:0] ea;
    to_frame_start();
    for (int j = 0; j < 17; j++) begin
      step();
      ea = (j >= 8 && j <= 13) ? 4'b1111 : AN_EXP[(j/4)%4];
      checks++;
      if (an !== ea) begin
        errors++;
        $display("FAIL enable pos %0d: an=%b, required %b", j, an, ea);
      end
      en = !(j >= 7 && j <= 12);
    end
  endtask
  task automatic test_midreset();
    to_frame_start();
    for (int j = 0; j < 3; j++) step();
    rst = 1'b1; en = 1'b1;
    step();
    checks++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
      errors++;
      $display("FAIL midreset_hold: an=%b seg=%b dp=%b, required an=1111 seg=1111111 dp=1", an, seg, dp);
    end
    rst = 1'b0; k = 0;
    for (int j = 0; j < 5; j++) begin
      step();
      checks++;
      if (an !== AN_EXP[j/4] || seg !== 7'b1000000) begin
        errors++;
        $display("FAIL midreset_restart pos %0d: an=%b seg=%b, required an=%b seg=1000000", j, an, seg, AN_EXP[j/4]);
      end
    end
  endtask
  initial begin
    test_reset();
    test_scan();
    test_leading_zero();
    test_dash_dp();
    test_tearing();
    test_enable();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
